// File: rtl/store_queue.sv
// store_queue: speculative byte-masked store queue with in-order drain and youngest-first load forwarding
module store_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    input  logic [ADDR_W-1:0] alloc_addr_i,
    input  logic [DATA_W-1:0] alloc_data_i,
    input  logic [1:0]        alloc_size_i,
    output logic [IDX_W-1:0]  alloc_idx_o,
    output logic              alloc_err_o,
    input  logic              commit_valid_i,
    input  logic [IDX_W-1:0]  commit_idx_i,
    input  logic [DEPTH-1:0]  discard_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [1:0]        ld_size_i,
    output logic              ld_hit_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              ld_stall_o,
    output logic              drain_valid_o,
    input  logic              drain_ready_i,
    output logic [ADDR_W-1:0] drain_addr_o,
    output logic [DATA_W-1:0] drain_data_o,
    output logic [NB-1:0]     drain_be_o,
    output logic [IDX_W:0]    count_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int OW = $clog2(NB);
    typedef enum logic [1:0] {FREE, SPEC, COMM, DEAD} st_t;
    st_t                    st   [DEPTH];
    st_t                    st_n [DEPTH];
    logic [ADDR_W-OW-1:0]   wa   [DEPTH];
    logic [DATA_W-1:0]      dat  [DEPTH];
    logic [NB-1:0]          be   [DEPTH];
    logic [IDX_W-1:0]       head, tail, j;
    logic [IDX_W:0]         count;
    logic [OW-1:0]          a_off, l_off;
    logic [NB-1:0]          a_be, l_be, cov;
    logic [DATA_W-1:0]      fw;
    logic                   do_alloc, do_ret;

    function automatic logic [NB-1:0] size_mask(input logic [1:0] s);
        return s == 2'd0 ? NB'(1) : s == 2'd1 ? NB'(3) : s == 2'd2 ? {NB{1'b1}} : {NB{1'b0}};
    endfunction

    assign a_off         = alloc_addr_i[OW-1:0];
    assign a_be          = size_mask(alloc_size_i) << a_off;
    assign alloc_err_o   = (alloc_size_i == 2'd3) || (alloc_size_i == 2'd1 && a_off[0]) ||
                           (alloc_size_i == 2'd2 && a_off != '0);
    assign count_o       = count;
    assign full_o        = count == (IDX_W+1)'(DEPTH);
    assign empty_o       = count == '0;
    assign alloc_ready_o = !full_o;
    assign alloc_idx_o   = tail;
    assign do_alloc      = alloc_valid_i && alloc_ready_o && !alloc_err_o;
    assign drain_valid_o = st[head] == COMM;
    assign do_ret        = (drain_valid_o && drain_ready_i) || st[head] == DEAD;
    assign drain_addr_o  = drain_valid_o ? {wa[head], OW'(0)} : '0;
    assign drain_data_o  = drain_valid_o ? dat[head] : '0;
    assign drain_be_o    = drain_valid_o ? be[head] : '0;

    // discard beats commit; a fresh allocation overrides whatever the freed slot saw
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_n[i] = st[i];
            if (st[i] == SPEC && discard_i[i])
                st_n[i] = DEAD;
            else if (st[i] == SPEC && commit_valid_i && commit_idx_i == IDX_W'(i))
                st_n[i] = COMM;
            if (do_ret && head == IDX_W'(i))
                st_n[i] = FREE;
            if (do_alloc && tail == IDX_W'(i))
                st_n[i] = SPEC;
        end
    end

    // walk oldest to youngest so younger stores overwrite older bytes
    always_comb begin
        l_off = ld_addr_i[OW-1:0];
        l_be  = size_mask(ld_size_i) << l_off;
        fw    = '0;
        cov   = '0;
        j     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            j = head + IDX_W'(k);
            if ((st[j] == SPEC || st[j] == COMM) && wa[j] == ld_addr_i[ADDR_W-1:OW])
                for (int b = 0; b < NB; b++)
                    if (be[j][b] && l_be[b]) begin
                        fw[8*b +: 8] = dat[j][8*b +: 8];
                        cov[b]       = 1'b1;
                    end
        end
        ld_data_o  = fw >> {l_off, 3'b000};
        ld_hit_o   = ld_valid_i && l_be != '0 && cov == l_be;
        ld_stall_o = ld_valid_i && cov != '0 && cov != l_be;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
        end else begin
            st    <= st_n;
            head  <= head + IDX_W'(do_ret);
            tail  <= tail + IDX_W'(do_alloc);
            count <= count + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_ret);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_alloc) begin
            wa[tail]  <= alloc_addr_i[ADDR_W-1:OW];
            dat[tail] <= alloc_data_i << {a_off, 3'b000};
            be[tail]  <= a_be;
        end
    end
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed self-checking bench for store_queue with DEPTH=4, 32-bit data
module tb_store_queue;
    logic        clk_i = 0, rst_i = 1;
    logic        alloc_valid_i = 0, alloc_ready_o, alloc_err_o;
    logic [31:0] alloc_addr_i = 0, alloc_data_i = 0;
    logic [1:0]  alloc_size_i = 0, alloc_idx_o;
    logic        commit_valid_i = 0;
    logic [1:0]  commit_idx_i = 0;
    logic [3:0]  discard_i = 0;
    logic        ld_valid_i = 0, ld_hit_o, ld_stall_o;
    logic [31:0] ld_addr_i = 0, ld_data_o;
    logic [1:0]  ld_size_i = 0;
    logic        drain_valid_o, drain_ready_i = 0;
    logic [31:0] drain_addr_o, drain_data_o;
    logic [3:0]  drain_be_o;
    logic [2:0]  count_o;
    logic        empty_o, full_o;
    int          checks = 0, errors = 0;

    store_queue dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_addr_i(alloc_addr_i),
        .alloc_data_i(alloc_data_i), .alloc_size_i(alloc_size_i), .alloc_idx_o(alloc_idx_o),
        .alloc_err_o(alloc_err_o), .commit_valid_i(commit_valid_i), .commit_idx_i(commit_idx_i),
        .discard_i(discard_i), .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_size_i(ld_size_i),
        .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_stall_o(ld_stall_o),
        .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i), .drain_addr_o(drain_addr_o),
        .drain_data_o(drain_data_o), .drain_be_o(drain_be_o), .count_o(count_o),
        .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        alloc_valid_i = 1; alloc_addr_i = a; alloc_data_i = d; alloc_size_i = s;
    endtask

    task automatic probe(input logic [31:0] a, input logic [1:0] s);
        ld_valid_i = 1; ld_addr_i = a; ld_size_i = s; #1;
    endtask

    initial begin
        step(); step();
        rst_i = 0; #1;
        chk("rst_ready", alloc_ready_o, 1);
        chk("rst_idx", alloc_idx_o, 0);
        chk("rst_dvalid", drain_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_hit", ld_hit_o, 0);
        chk("rst_stall", ld_stall_o, 0);
        chk("rst_err", alloc_err_o, 0);
        chk("rst_daddr", drain_addr_o, 0);
        chk("rst_ddata", drain_data_o, 0);
        chk("rst_dbe", drain_be_o, 0);

        // word store, commit, drain
        alloc(32'h100, 32'hDEADBEEF, 2); #1;
        chk("w_err", alloc_err_o, 0);
        chk("w_idx", alloc_idx_o, 0);
        step(); alloc_valid_i = 0; #1;
        chk("w_count", count_o, 1);
        chk("w_spec_nodrain", drain_valid_o, 0);
        commit_valid_i = 1; commit_idx_i = 0; drain_ready_i = 1; #1;
        chk("w_commit_edge", drain_valid_o, 0);
        step(); commit_valid_i = 0; #1;
        chk("w_dvalid", drain_valid_o, 1);
        chk("w_daddr", drain_addr_o, 32'h100);
        chk("w_ddata", drain_data_o, 32'hDEADBEEF);
        chk("w_dbe", drain_be_o, 4'hF);
        step();
        chk("w_empty", empty_o, 1);
        chk("w_dvalid_off", drain_valid_o, 0);

        // sub-word stores and forwarding
        alloc(32'h101, 32'hAA, 0); #1;
        chk("b_idx", alloc_idx_o, 1);
        step();
        alloc(32'h102, 32'h1234, 1); #1;
        chk("h_idx", alloc_idx_o, 2);
        step(); alloc_valid_i = 0;
        probe(32'h100, 2);
        chk("fw_word_stall", ld_stall_o, 1);
        chk("fw_word_hit", ld_hit_o, 0);
        probe(32'h102, 1);
        chk("fw_half_hit", ld_hit_o, 1);
        chk("fw_half_data", ld_data_o, 32'h1234);
        chk("fw_half_stall", ld_stall_o, 0);
        probe(32'h101, 0);
        chk("fw_byte_hit", ld_hit_o, 1);
        chk("fw_byte_data", ld_data_o, 32'hAA);
        probe(32'h100, 0);
        chk("fw_none_hit", ld_hit_o, 0);
        chk("fw_none_stall", ld_stall_o, 0);
        ld_valid_i = 0; ld_addr_i = 32'h101; #1;
        chk("fw_novalid_hit", ld_hit_o, 0);
        commit_valid_i = 1; commit_idx_i = 1; discard_i = 4'b0100; drain_ready_i = 1;
        step(); commit_valid_i = 0; discard_i = 0;
        probe(32'h102, 1);
        chk("dead_nofw_hit", ld_hit_o, 0);
        chk("dead_nofw_stall", ld_stall_o, 0);
        chk("b_dvalid", drain_valid_o, 1);
        chk("b_daddr", drain_addr_o, 32'h100);
        chk("b_ddata", drain_data_o, 32'h0000AA00);
        chk("b_dbe", drain_be_o, 4'h2);
        probe(32'h101, 0);
        chk("drain_fw_hit", ld_hit_o, 1);
        ld_valid_i = 0;
        step();
        chk("dead_head_nodrain", drain_valid_o, 0);
        chk("dead_head_count", count_o, 1);
        step();
        chk("sub_count0", count_o, 0);
        chk("sub_empty", empty_o, 1);

        // misalignment
        alloc(32'h103, 32'h55, 1); #1;
        chk("mis_half_err", alloc_err_o, 1);
        step();
        chk("mis_count", count_o, 0);
        alloc_size_i = 3; alloc_addr_i = 32'h100; #1;
        chk("mis_rsvd_err", alloc_err_o, 1);
        alloc_size_i = 2; alloc_addr_i = 32'h102; #1;
        chk("mis_word_err", alloc_err_o, 1);
        alloc_size_i = 1; #1;
        chk("ok_half_err", alloc_err_o, 0);
        alloc_valid_i = 0;

        rst_i = 1; step(); rst_i = 0; #1;

        // fill, commit 0/1, discard 2/3, backpressure
        drain_ready_i = 0;
        for (int k = 0; k < 4; k++) begin
            alloc(32'h200 + 4 * k, 32'h11111111 * (k + 1), 2); #1;
            chk("fill_idx", alloc_idx_o, k);
            step();
        end
        alloc(32'h210, 32'h99, 2); #1;
        chk("full_flag", full_o, 1);
        chk("full_ready", alloc_ready_o, 0);
        chk("full_count", count_o, 4);
        step(); alloc_valid_i = 0;
        chk("full_reject_count", count_o, 4);
        commit_valid_i = 1; commit_idx_i = 0; discard_i = 4'b1100;
        step(); commit_idx_i = 1; discard_i = 0;
        step(); commit_valid_i = 0;
        for (int k = 0; k < 3; k++) begin
            chk("hold_valid", drain_valid_o, 1);
            chk("hold_addr", drain_addr_o, 32'h200);
            chk("hold_data", drain_data_o, 32'h11111111);
            chk("hold_full", full_o, 1);
            step();
        end
        drain_ready_i = 1; #1;
        chk("d0_addr", drain_addr_o, 32'h200);
        step();
        chk("d1_valid", drain_valid_o, 1);
        chk("d1_addr", drain_addr_o, 32'h204);
        chk("d1_data", drain_data_o, 32'h22222222);
        chk("d1_count", count_o, 3);
        step();
        chk("dead2_valid", drain_valid_o, 0);
        chk("dead2_count", count_o, 2);
        step();
        chk("dead3_count", count_o, 1);
        step();
        chk("fill_count0", count_o, 0);
        chk("fill_empty", empty_o, 1);

        // commit and discard together: discard wins
        alloc(32'h300, 32'h5, 2); step(); alloc_valid_i = 0;
        commit_valid_i = 1; commit_idx_i = 0; discard_i = 4'b0001;
        step(); commit_valid_i = 0; discard_i = 0;
        chk("cd_nodrain", drain_valid_o, 0);
        chk("cd_count", count_o, 1);
        step();
        chk("cd_count0", count_o, 0);
        chk("cd_nodrain2", drain_valid_o, 0);

        // reset during a pending drain
        alloc(32'h400, 32'h77, 2); #1;
        chk("rd_idx", alloc_idx_o, 1);
        step(); alloc_valid_i = 0;
        commit_valid_i = 1; commit_idx_i = 1; drain_ready_i = 0;
        step(); commit_valid_i = 0;
        chk("rd_pending", drain_valid_o, 1);
        rst_i = 1; step(); rst_i = 0; #1;
        chk("rd_dvalid", drain_valid_o, 0);
        chk("rd_empty", empty_o, 1);
        chk("rd_idx0", alloc_idx_o, 0);

        // nine stores through, tail wraps
        drain_ready_i = 1;
        for (int k = 0; k < 9; k++) begin
            alloc(32'h500 + 4 * k, 32'hA0000000 + k, 2); #1;
            chk("wrap_idx", alloc_idx_o, k % 4);
            step(); alloc_valid_i = 0;
            commit_valid_i = 1; commit_idx_i = 2'(k % 4);
            step(); commit_valid_i = 0;
            chk("wrap_valid", drain_valid_o, 1);
            chk("wrap_addr", drain_addr_o, 32'h500 + 4 * k);
            chk("wrap_data", drain_data_o, 32'hA0000000 + k);
            step();
            chk("wrap_empty", empty_o, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
